// File: rtl/alu_seq_if.sv
// Bundled command, ALU-control and result signals of the alu_seq sequencer.
// The sequencer is the slave; the command source, ALU and result consumer form the master.
interface alu_seq_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_a;
   logic [31:0] cmd_b;
   logic [3:0]  cmd_op;
   logic        cmd_keep_a;
   logic [31:0] data_out;
   logic        load_a;
   logic        load_b;
   logic [3:0]  alu_op;
   logic [31:0] alu_f;
   logic [3:0]  alu_fr;
   logic        capture_f;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_f;
   logic [3:0]  res_fr;
   logic        busy;
   logic [15:0] op_count;

   modport master (
      output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_keep_a, alu_f, alu_fr, res_ready,
      input  cmd_ready, data_out, load_a, load_b, alu_op, capture_f,
             res_valid, res_f, res_fr, busy, op_count
   );

   modport slave (
      input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_keep_a, alu_f, alu_fr, res_ready,
      output cmd_ready, data_out, load_a, load_b, alu_op, capture_f,
             res_valid, res_f, res_fr, busy, op_count
   );
endinterface

// File: rtl/alu_seq.sv
// Sequencer driving an external ALU: loads A and B over a shared bus, waits
// EXEC_CYCLES (legal 1..15), captures result and flags, and holds them for a handshake.
module alu_seq #(
   parameter int unsigned EXEC_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   alu_seq_if.slave   io_bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_A,
      S_LOAD_B,
      S_EXEC,
      S_CAPT,
      S_HOLD
   } state_t;

   state_t      r_state;
   logic [31:0] r_b;
   logic [3:0]  r_op;
   logic [3:0]  r_cnt;
   logic        r_cmd_ready;
   logic        r_busy;
   logic        r_load_a;
   logic        r_load_b;
   logic        r_capture_f;
   logic        r_res_valid;
   logic [31:0] r_data_out;
   logic [31:0] r_res_f;
   logic [3:0]  r_res_fr;
   logic [15:0] r_op_count;

   // Outputs are registered alongside the state, so each transition sets the
   // decode of the state being entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_b         <= '0;
         r_op        <= '0;
         r_cnt       <= '0;
         r_cmd_ready <= 1'b1;
         r_busy      <= 1'b0;
         r_load_a    <= 1'b0;
         r_load_b    <= 1'b0;
         r_capture_f <= 1'b0;
         r_res_valid <= 1'b0;
         r_data_out  <= '0;
         r_res_f     <= '0;
         r_res_fr    <= '0;
         r_op_count  <= '0;
      end else begin
         // NOTE: non-blocking defaults here are overridden by later assignments in the
         // same block, making every strobe a single-cycle pulse without extra logic.
         r_load_a    <= 1'b0;
         r_load_b    <= 1'b0;
         r_capture_f <= 1'b0;
         r_data_out  <= '0;
         case (r_state)
            S_IDLE: begin
               if (io_bus.cmd_valid) begin
                  r_b         <= io_bus.cmd_b;
                  r_op        <= io_bus.cmd_op;
                  r_cmd_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  if (io_bus.cmd_keep_a) begin
                     r_state    <= S_LOAD_B;
                     r_load_b   <= 1'b1;
                     r_data_out <= io_bus.cmd_b;
                  end else begin
                     r_state    <= S_LOAD_A;
                     r_load_a   <= 1'b1;
                     r_data_out <= io_bus.cmd_a;
                  end
               end
            end
            S_LOAD_A: begin
               r_state    <= S_LOAD_B;
               r_load_b   <= 1'b1;
               r_data_out <= r_b;
            end
            S_LOAD_B: begin
               r_state <= S_EXEC;
               r_cnt   <= 4'(EXEC_CYCLES);
            end
            S_EXEC: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  r_state     <= S_CAPT;
                  r_capture_f <= 1'b1;
               end
            end
            S_CAPT: begin
               r_state     <= S_HOLD;
               r_res_f     <= io_bus.alu_f;
               r_res_fr    <= io_bus.alu_fr;
               r_res_valid <= 1'b1;
            end
            S_HOLD: begin
               if (io_bus.res_ready) begin
                  r_state     <= S_IDLE;
                  r_res_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  if (r_op_count != 16'hFFFF) begin
                     r_op_count <= r_op_count + 16'd1;
                  end
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_res_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_cmd_ready <= 1'b1;
            end
         endcase
      end
   end

   assign io_bus.cmd_ready = r_cmd_ready;
   assign io_bus.busy      = r_busy;
   assign io_bus.load_a    = r_load_a;
   assign io_bus.load_b    = r_load_b;
   assign io_bus.capture_f = r_capture_f;
   assign io_bus.res_valid = r_res_valid;
   assign io_bus.data_out  = r_data_out;
   assign io_bus.alu_op    = r_op;
   assign io_bus.res_f     = r_res_f;
   assign io_bus.res_fr    = r_res_fr;
   assign io_bus.op_count  = r_op_count;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: two instances (EXEC_CYCLES 1 and 4) share clock and
// reset; a small ALU model with its own A/B registers answers each instance.
`timescale 1ns/1ps
module tb_alu_seq;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   alu_seq_if if1 ();
   alu_seq_if if4 ();

   alu_seq #(.EXEC_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .io_bus(if1));
   alu_seq #(.EXEC_CYCLES(4)) dut4 (.clk(clk), .rst(rst), .io_bus(if4));

   // Stimulus goes to the instance picked by s4; the other sees idle inputs.
   logic        s4 = 1'b0;
   logic        t_valid = 1'b0;
   logic [31:0] t_a = '0;
   logic [31:0] t_b = '0;
   logic [3:0]  t_op = '0;
   logic        t_keep = 1'b0;
   logic        t_rready = 1'b0;

   assign if1.cmd_valid  = t_valid & ~s4;
   assign if4.cmd_valid  = t_valid & s4;
   assign if1.res_ready  = t_rready & ~s4;
   assign if4.res_ready  = t_rready & s4;
   assign if1.cmd_a      = t_a;
   assign if4.cmd_a      = t_a;
   assign if1.cmd_b      = t_b;
   assign if4.cmd_b      = t_b;
   assign if1.cmd_op     = t_op;
   assign if4.cmd_op     = t_op;
   assign if1.cmd_keep_a = t_keep;
   assign if4.cmd_keep_a = t_keep;

   // ALU model: returns {ZF,SF,OF,CF, F}; CF on subtract is the borrow.
   function automatic logic [35:0] alu_calc(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
      logic [32:0] w;
      logic [31:0] f;
      logic        ofl;
      logic        cf;
      w   = '0;
      ofl = 1'b0;
      cf  = 1'b0;
      case (op)
         OP_ADD: begin
            w   = {1'b0, a} + {1'b0, b};
            f   = w[31:0];
            cf  = w[32];
            ofl = (a[31] == b[31]) && (f[31] != a[31]);
         end
         OP_SUB: begin
            w   = {1'b0, a} - {1'b0, b};
            f   = w[31:0];
            cf  = w[32];
            ofl = (a[31] != b[31]) && (f[31] != a[31]);
         end
         OP_AND:  f = a & b;
         OP_OR:   f = a | b;
         default: f = a ^ b;
      endcase
      return {(f == 32'h0), f[31], ofl, cf, f};
   endfunction

   logic [31:0] m1_a = '0, m1_b = '0, m4_a = '0, m4_b = '0;
   always @(posedge clk) begin
      if (if1.load_a) m1_a <= if1.data_out;
      if (if1.load_b) m1_b <= if1.data_out;
      if (if4.load_a) m4_a <= if4.data_out;
      if (if4.load_b) m4_b <= if4.data_out;
   end
   assign {if1.alu_fr, if1.alu_f} = alu_calc(if1.alu_op, m1_a, m1_b);
   assign {if4.alu_fr, if4.alu_f} = alu_calc(if4.alu_op, m4_a, m4_b);

   // Observation view of the selected instance.
   logic        o_ready, o_busy, o_la, o_lb, o_cap, o_rv;
   logic [31:0] o_do, o_rf;
   logic [3:0]  o_op, o_rfr;
   logic [15:0] o_cnt;
   assign o_ready = s4 ? if4.cmd_ready : if1.cmd_ready;
   assign o_busy  = s4 ? if4.busy      : if1.busy;
   assign o_la    = s4 ? if4.load_a    : if1.load_a;
   assign o_lb    = s4 ? if4.load_b    : if1.load_b;
   assign o_cap   = s4 ? if4.capture_f : if1.capture_f;
   assign o_rv    = s4 ? if4.res_valid : if1.res_valid;
   assign o_do    = s4 ? if4.data_out  : if1.data_out;
   assign o_rf    = s4 ? if4.res_f     : if1.res_f;
   assign o_op    = s4 ? if4.alu_op    : if1.alu_op;
   assign o_rfr   = s4 ? if4.res_fr    : if1.res_fr;
   assign o_cnt   = s4 ? if4.op_count  : if1.op_count;

   // {cmd_ready,busy,load_a,load_b,capture_f,res_valid,data_out,alu_op,res_f,res_fr,op_count}
   localparam logic [93:0] RESET_VEC = {6'b100000, 88'h0};

   task automatic test_reset;
      logic [93:0] obs;
      for (int k = 0; k < 2; k++) begin
         s4 = (k == 1);
         #1;
         obs = {o_ready, o_busy, o_la, o_lb, o_cap, o_rv, o_do, o_op, o_rf, o_rfr, o_cnt};
         n_tests++;
         if (obs !== RESET_VEC) begin
            n_fail++;
            $display("FAIL reset_state dut%0d: got %h want %h", k, obs, RESET_VEC);
         end
      end
      s4 = 1'b0;
   endtask

   // Runs one command and checks every strobe cycle by cycle against the schedule
   // implied by keep_a and EXEC_CYCLES; stall>0 adds HOLD cycles with stray requests.
   task automatic run_cmd(input string name, input logic sel, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] op, input logic keep,
                          input logic [31:0] ef, input logic [3:0] efr, input int stall,
                          input logic [15:0] ecnt);
      int e, lb, cap, last;
      logic x_la, x_lb, x_cap, x_rv;
      logic [31:0] x_do;
      e    = sel ? 4 : 1;
      lb   = keep ? 1 : 2;
      cap  = lb + 1 + e;
      last = cap + 1 + stall;
      @(negedge clk);
      s4 = sel;
      #1;
      n_tests++;
      if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s idle: ready=%b busy=%b want 1 0", name, o_ready, o_busy);
      end
      t_valid = 1'b1; t_a = a; t_b = b; t_op = op; t_keep = keep; t_rready = 1'b0;
      for (int cyc = 1; cyc <= last; cyc++) begin
         @(negedge clk);
         x_la  = !keep && (cyc == 1);
         x_lb  = (cyc == lb);
         x_cap = (cyc == cap);
         x_rv  = (cyc > cap);
         x_do  = x_la ? a : (x_lb ? b : 32'h0);
         n_tests++;
         if ({o_la, o_lb, o_cap, o_rv, o_ready, o_busy} !== {x_la, x_lb, x_cap, x_rv, 2'b01} ||
             o_do !== x_do || o_op !== op) begin
            n_fail++;
            $display("FAIL %s cyc%0d: la/lb/cap/rv/rdy/busy=%b%b%b%b%b%b do=%h op=%h want %b%b%b%b01 do=%h op=%h",
                     name, cyc, o_la, o_lb, o_cap, o_rv, o_ready, o_busy, o_do, o_op,
                     x_la, x_lb, x_cap, x_rv, x_do, op);
         end
         if (x_rv) begin
            n_tests++;
            if (o_rf !== ef || o_rfr !== efr) begin
               n_fail++;
               $display("FAIL %s result cyc%0d: f=%h fr=%b want f=%h fr=%b",
                        name, cyc, o_rf, o_rfr, ef, efr);
            end
         end
         // Stray requests with different operands must be ignored while busy.
         t_valid = (stall > 0) && (cyc % 2 == 1) && (cyc != last);
         t_a = ~a; t_b = ~b; t_op = ~op; t_keep = ~keep;
         t_rready = (cyc == last) || ((stall > 0) && (cyc < cap));
      end
      @(negedge clk);
      t_valid = 1'b0; t_rready = 1'b0;
      n_tests++;
      if ({o_ready, o_busy, o_rv} !== 3'b100 || o_cnt !== ecnt || o_rf !== ef || o_rfr !== efr) begin
         n_fail++;
         $display("FAIL %s done: rdy/busy/rv=%b%b%b cnt=%h f=%h fr=%b want 100 cnt=%h f=%h fr=%b",
                  name, o_ready, o_busy, o_rv, o_cnt, o_rf, o_rfr, ecnt, ef, efr);
      end
   endtask

   task automatic test_basic_add;
      run_cmd("add_5_3", 1'b0, 32'h5, 32'h3, OP_ADD, 1'b0, 32'h8, 4'b0000, 0, 16'd1);
   endtask

   task automatic test_keep_a;
      run_cmd("load_7fff", 1'b0, 32'h7FFFFFFF, 32'h0, OP_ADD, 1'b0, 32'h7FFFFFFF, 4'b0000, 0, 16'd2);
      run_cmd("keep_a_add", 1'b0, 32'hDEADBEEF, 32'h1, OP_ADD, 1'b1, 32'h80000000, 4'b0110, 0, 16'd3);
   endtask

   task automatic test_alu_ops;
      run_cmd("sub_3_5", 1'b0, 32'h3, 32'h5, OP_SUB, 1'b0, 32'hFFFFFFFE, 4'b0101, 0, 16'd4);
      run_cmd("and_zero", 1'b0, 32'hF0F0F0F0, 32'h0F0F0F0F, OP_AND, 1'b0, 32'h0, 4'b1000, 0, 16'd5);
   endtask

   task automatic test_hold_stall;
      run_cmd("e4_stall", 1'b1, 32'h12340000, 32'h00005678, OP_OR, 1'b0, 32'h12345678, 4'b0000, 10, 16'd1);
   endtask

   task automatic test_reset_mid_exec;
      logic [93:0] obs;
      @(negedge clk);
      s4 = 1'b1;
      t_valid = 1'b1; t_a = 32'h9; t_b = 32'h4; t_op = OP_SUB; t_keep = 1'b0; t_rready = 1'b0;
      for (int cyc = 1; cyc <= 4; cyc++) begin
         @(negedge clk);
         t_valid = 1'b0;
      end
      n_tests++;
      if (o_busy !== 1'b1 || o_op !== OP_SUB || {o_la, o_lb, o_cap} !== 3'b000) begin
         n_fail++;
         $display("FAIL rst_exec pre: busy=%b op=%h strobes=%b%b%b want busy=1 op=1 000",
                  o_busy, o_op, o_la, o_lb, o_cap);
      end
      #2 rst = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         s4 = (k == 0);
         #0.1;
         obs = {o_ready, o_busy, o_la, o_lb, o_cap, o_rv, o_do, o_op, o_rf, o_rfr, o_cnt};
         n_tests++;
         if (obs !== RESET_VEC) begin
            n_fail++;
            $display("FAIL rst_exec async dut_sel4=%0d: got %h want %h", s4, obs, RESET_VEC);
         end
      end
      s4 = 1'b1;
      #0.5 rst = 1'b0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clk);
         n_tests++;
         if ({o_la, o_lb, o_cap, o_rv, o_ready, o_busy} !== 6'b000010 || o_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL rst_exec after cyc%0d: la/lb/cap/rv/rdy/busy=%b%b%b%b%b%b cnt=%h want 000010 cnt=0",
                     cyc, o_la, o_lb, o_cap, o_rv, o_ready, o_busy, o_cnt);
         end
      end
      s4 = 1'b0;
   endtask

   task automatic test_back_to_back;
      int caps;
      logic x_ready;
      caps = 0;
      @(negedge clk);
      s4 = 1'b0;
      t_a = 32'h1; t_b = 32'h2; t_op = OP_ADD; t_keep = 1'b0; t_valid = 1'b1; t_rready = 1'b1;
      #1;
      n_tests++;
      if (o_ready !== 1'b1 || o_cnt !== 16'h0) begin
         n_fail++;
         $display("FAIL b2b start: ready=%b cnt=%h want 1 0", o_ready, o_cnt);
      end
      for (int cyc = 1; cyc <= 18; cyc++) begin
         @(negedge clk);
         if (o_cap === 1'b1) caps++;
         x_ready = (cyc % 6 == 0);
         n_tests++;
         if (o_ready !== x_ready) begin
            n_fail++;
            $display("FAIL b2b ready cyc%0d: got %b want %b", cyc, o_ready, x_ready);
         end
         if (cyc % 6 == 5) begin
            n_tests++;
            if (o_rv !== 1'b1 || o_rf !== 32'h3) begin
               n_fail++;
               $display("FAIL b2b result cyc%0d: rv=%b f=%h want 1 3", cyc, o_rv, o_rf);
            end
         end
         if (cyc == 18) t_valid = 1'b0;
      end
      t_rready = 1'b0;
      n_tests++;
      if (caps != 3 || o_cnt !== 16'd3) begin
         n_fail++;
         $display("FAIL b2b totals: captures=%0d cnt=%0d want 3 3", caps, o_cnt);
      end
   endtask

   task automatic test_saturation;
      @(negedge clk);
      force dut1.r_op_count = 16'hFFFE;
      #1 release dut1.r_op_count;
      run_cmd("sat_to_max", 1'b0, 32'hFFFF0000, 32'hFFFFFFFF, OP_XOR, 1'b0, 32'h0000FFFF, 4'b0000, 0, 16'hFFFF);
      run_cmd("sat_hold", 1'b0, 32'h0, 32'h0000FFFF, OP_ADD, 1'b1, 32'hFFFFFFFF, 4'b0100, 0, 16'hFFFF);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      test_reset;
      test_basic_add;
      test_keep_a;
      test_alu_ops;
      test_hold_stall;
      test_reset_mid_exec;
      test_back_to_back;
      test_saturation;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter EXEC_CYCLES, default 1, ALU settle cycles between B load and result capture; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  controller can accept a command.
REQ-006 cmd_a  input  32  operand A.
REQ-007 cmd_b  input  32  operand B.
REQ-008 cmd_op  input  4  ALU opcode.
REQ-009 cmd_keep_a  input  1  reuse A already held in the ALU A register; skip A load.
REQ-010 data_out  output  32  shared operand bus to the ALU A/B registers.
REQ-011 load_a  output  1  one-cycle load strobe for the A register.
REQ-012 load_b  output  1  one-cycle load strobe for the B register.
REQ-013 alu_op  output  4  opcode driven to the ALU.
REQ-014 alu_f  input  32  ALU result.
REQ-015 alu_fr  input  4  ALU flags {ZF,SF,OF,CF}.
REQ-016 capture_f  output  1  one-cycle strobe for the result/flag registers.
REQ-017 res_valid  output  1  result available.
REQ-018 res_ready  input  1  consumer accepts result.
REQ-019 res_f  output  32  captured result.
REQ-020 res_fr  output  4  captured flags.
REQ-021 busy  output  1  high in every state except IDLE.
REQ-022 op_count  output  16  completed-operation counter.

Function
REQ-023 FSM states: IDLE, LOAD_A, LOAD_B, EXEC, CAPT, HOLD; Moore decode of cmd_ready, load_a, load_b, capture_f, res_valid, busy.
REQ-024 IDLE: cmd_ready=1; on cmd_valid=1 latch cmd_a, cmd_b, cmd_op, cmd_keep_a; go LOAD_B if cmd_keep_a=1, else LOAD_A.
REQ-025 LOAD_A: load_a=1, data_out=latched A; next LOAD_B.
REQ-026 LOAD_B: load_b=1, data_out=latched B; load EXEC counter with EXEC_CYCLES; next EXEC.
REQ-027 EXEC: decrement counter each cycle; go CAPT in the cycle the counter is 1 (EXEC lasts exactly EXEC_CYCLES cycles).
REQ-028 CAPT: capture_f=1; register alu_f into res_f and alu_fr into res_fr at that edge; next HOLD.
REQ-029 HOLD: res_valid=1, res_f/res_fr stable; on res_ready=1 go IDLE and increment op_count.
REQ-030 data_out = 0 outside LOAD_A/LOAD_B; alu_op = latched opcode at all times (0 after reset until first accept).
REQ-031 Latency (accept edge = cycle 0): res_valid first high at cycle 4+EXEC_CYCLES without keep_a, 3+EXEC_CYCLES with keep_a.
REQ-032 cmd_ready=0 outside IDLE; cmd_valid and cmd inputs ignored there; no command queuing.
REQ-033 res_ready outside HOLD has no effect; res_valid&res_ready in HOLD returns to IDLE in one cycle, next command accepted no earlier than the following edge.
REQ-034 op_count saturates at 0xFFFF; no wrap.
REQ-035 res_f/res_fr retain last captured values in IDLE until the next CAPT.
REQ-036 At most one of load_a, load_b, capture_f high in any cycle.

Reset
REQ-037 rst=1 forces immediately, regardless of state: state IDLE, cmd_ready=1, busy=0, load_a=load_b=capture_f=0, res_valid=0, data_out=0, alu_op=0, res_f=0, res_fr=0, op_count=0, EXEC counter=0.
REQ-038 Reset mid-operation discards the in-flight command; no strobe is issued after rst deasserts until a new command is accepted.

Verification
REQ-039 EXEC_CYCLES=1, A=0x00000005, B=0x00000003, op=add, alu model add -> load_a cycle 1 data_out=5, load_b cycle 2 data_out=3, capture_f cycle 4, res_valid cycle 5, res_f=0x00000008, res_fr=0000, op_count=1 after res_ready.
REQ-040 cmd_keep_a=1, B=0x00000001 after previous A=0x7FFFFFFF, add -> no load_a, res_f=0x80000000, OF=1, SF=1, res_valid one cycle earlier than REQ-039.
REQ-041 EXEC_CYCLES=4, res_ready held low 10 cycles -> capture_f at cycle 7, res_valid held with stable res_f, cmd_ready=0 until handshake, cmd_valid pulses in between ignored.
REQ-042 rst pulse while in EXEC -> all outputs at REQ-037 values asynchronously, no capture_f afterwards, op_count=0.
REQ-043 Back-to-back: cmd_valid held high, res_ready held high, 3 commands -> each completes, cmd_ready high one cycle between, op_count=3; preload op_count near 0xFFFF via 65535 ops (or force) -> stays 0xFFFF.
